// File: rtl/latch_chk.sv
`default_nettype none
// ============================================================================
//  Module   : latch_chk
//  Purpose  : Run-based checker for a level-sensitive D latch. After a start
//             request it samples the latch stimulus (en, d) and the latch
//             outputs (q, qb) for WINDOW consecutive cycles. Each sample is
//             compared against a reference latch model and against the
//             complementary-output rule. Mismatches are counted into a
//             saturating error counter, and a pass/fail verdict is produced.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WINDOW   samples per check run (1..255)
//    ERR_W    error counter width; the counter saturates at 2^ERR_W-1
//  Ports
//    clk        in   rising-edge clock
//    rst_n      in   asynchronous active-low reset
//    start      in   begin a run (honoured in IDLE only)
//    abort      in   cancel a run (honoured in ARM and CHECK only)
//    en, d      in   enable and data as driven to the latch under test
//    q, qb      in   true and complementary latch outputs
//    busy       out  run in progress (ARM, CHECK, FLUSH)
//    done       out  one-cycle pulse on normal completion
//    pass       out  verdict of the last completed run
//    err_pulse  out  one-cycle pulse in the cycle after an erroneous sample
//    err_cnt    out  erroneous samples in the current/last run
//    chk_cnt    out  samples taken in the current/last run
// ============================================================================
module latch_chk #(
  parameter int WINDOW = 40,
  parameter int ERR_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             en,
  input  logic             d,
  input  logic             q,
  input  logic             qb,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [7:0]       chk_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_CHECK = 3'd2,
    ST_END   = 3'd3,
    ST_FLUSH = 3'd4
  } state_t;

  localparam logic [7:0]       C_WINDOW  = 8'(WINDOW);
  localparam logic [ERR_W-1:0] C_ERR_MAX = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] C_ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t           state_q,     state_d;
  logic [ERR_W-1:0] err_cnt_q,   err_cnt_d;
  logic [7:0]       chk_cnt_q,   chk_cnt_d;
  logic             pass_q,      pass_d;
  logic             err_pulse_q, err_pulse_d;
  // Reference latch: last d captured while en was high, plus a flag telling
  // whether anything has been captured yet in this run.
  logic             ref_q,       ref_d;
  logic             ref_vld_q,   ref_vld_d;

  // --------------------------------------------------------------------------
  // Per-sample evaluation
  // --------------------------------------------------------------------------
  logic       exp_vld;
  logic       exp_val;
  logic       q_bad;
  logic       qb_bad;
  logic       sample_bad;
  logic [7:0] chk_cnt_inc;

  always_comb begin
    // A transparent latch follows d in the same sample, so an en=1 sample
    // both defines the expected value and makes the model valid at once.
    exp_vld     = en | ref_vld_q;
    exp_val     = en ? d : ref_q;
    q_bad       = exp_vld && (q != exp_val);
    // qb must be the complement of the observed q, independent of the model.
    qb_bad      = (qb == q);
    // Both faults in one sample still count as a single error.
    sample_bad  = q_bad | qb_bad;
    chk_cnt_inc = chk_cnt_q + 8'd1;
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath updates
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    err_cnt_d   = err_cnt_q;
    chk_cnt_d   = chk_cnt_q;
    pass_d      = pass_q;
    err_pulse_d = 1'b0;
    ref_d       = ref_q;
    ref_vld_d   = ref_vld_q;

    case (state_q)
      ST_IDLE: begin
        // start with a simultaneous abort is treated as no request.
        if (start && !abort) begin
          state_d = ST_ARM;
        end
      end

      ST_ARM: begin
        err_cnt_d = '0;
        chk_cnt_d = '0;
        ref_vld_d = 1'b0;
        state_d   = abort ? ST_FLUSH : ST_CHECK;
      end

      ST_CHECK: begin
        if (abort) begin
          // The sample presented with abort is neither checked nor counted.
          state_d = ST_FLUSH;
        end else begin
          if (en) begin
            ref_d     = d;
            ref_vld_d = 1'b1;
          end
          chk_cnt_d = chk_cnt_inc;
          if (sample_bad) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != C_ERR_MAX) begin
              err_cnt_d = err_cnt_q + C_ERR_ONE;
            end
          end
          if (chk_cnt_inc == C_WINDOW) begin
            state_d = ST_END;
          end
        end
      end

      ST_END: begin
        // err_cnt is final here; the verdict becomes visible after END.
        pass_d  = (err_cnt_q == '0);
        state_d = ST_IDLE;
      end

      ST_FLUSH: begin
        ref_vld_d = 1'b0;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      err_cnt_q   <= '0;
      chk_cnt_q   <= '0;
      pass_q      <= 1'b0;
      err_pulse_q <= 1'b0;
      ref_q       <= 1'b0;
      ref_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_cnt_q   <= err_cnt_d;
      chk_cnt_q   <= chk_cnt_d;
      pass_q      <= pass_d;
      err_pulse_q <= err_pulse_d;
      ref_q       <= ref_d;
      ref_vld_q   <= ref_vld_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // busy and done decode the state register directly, so an asynchronous
  // reset clears them without waiting for a clock edge.
  always_comb begin
    busy = (state_q == ST_ARM) || (state_q == ST_CHECK) || (state_q == ST_FLUSH);
    done = (state_q == ST_END);
  end

  assign pass      = pass_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign chk_cnt   = chk_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_latch_chk.sv
`default_nettype none
// ============================================================================
//  Module   : tb_latch_chk
//  Purpose  : Self-checking bench for latch_chk (WINDOW=40, ERR_W=4).
//             A behavioural model of a check run predicts all outputs every
//             cycle; directed runs add hand-computed end-of-run expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_latch_chk;

  localparam int WIN     = 40;
  localparam int ERR_MAX = 15;

  localparam int M_IDLE  = 0;
  localparam int M_ARM   = 1;
  localparam int M_CHECK = 2;
  localparam int M_END   = 3;
  localparam int M_FLUSH = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       en    = 1'b0;
  logic       d     = 1'b0;
  logic       q     = 1'b0;
  logic       qb    = 1'b1;
  logic       busy;
  logic       done;
  logic       pass;
  logic       err_pulse;
  logic [3:0] err_cnt;
  logic [7:0] chk_cnt;

  int total = 0;
  int bad   = 0;
  int n_pulse = 0;
  int n_done  = 0;

  latch_chk #(.WINDOW(WIN), .ERR_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .en        (en),
    .d         (d),
    .q         (q),
    .qb        (qb),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .chk_cnt   (chk_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: phase of the run, sample count, error count and the
  // most recent d seen with en high.
  // --------------------------------------------------------------------------
  int m_phase = M_IDLE;
  int m_err   = 0;
  int m_chk   = 0;
  int m_pass  = 0;
  int m_pulse = 0;
  int m_seen  = 0;
  int m_held  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = M_IDLE;
      m_err   = 0;
      m_chk   = 0;
      m_pass  = 0;
      m_pulse = 0;
      m_seen  = 0;
      m_held  = 0;
    end else begin
      m_pulse = 0;
      if (m_phase == M_IDLE) begin
        if (start && !abort) m_phase = M_ARM;
      end else if (m_phase == M_ARM) begin
        m_err   = 0;
        m_chk   = 0;
        m_seen  = 0;
        m_phase = abort ? M_FLUSH : M_CHECK;
      end else if (m_phase == M_CHECK) begin
        if (abort) begin
          m_phase = M_FLUSH;
        end else begin
          int wrong;
          if (en) begin
            m_seen = 1;
            m_held = int'(d);
          end
          wrong = 0;
          if (m_seen != 0 && int'(q) != m_held) wrong = 1;
          if (qb == q) wrong = 1;
          if (wrong != 0) begin
            m_pulse = 1;
            m_err   = (m_err + 1 > ERR_MAX) ? ERR_MAX : m_err + 1;
          end
          m_chk = m_chk + 1;
          if (m_chk == WIN) m_phase = M_END;
        end
      end else if (m_phase == M_END) begin
        m_pass  = (m_err == 0) ? 1 : 0;
        m_phase = M_IDLE;
      end else begin
        m_seen  = 0;
        m_phase = M_IDLE;
      end
    end
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    int e_busy;
    e_busy = (m_phase == M_ARM || m_phase == M_CHECK || m_phase == M_FLUSH) ? 1 : 0;
    check("busy",      int'(busy),      e_busy);
    check("done",      int'(done),      (m_phase == M_END) ? 1 : 0);
    check("pass",      int'(pass),      m_pass);
    check("err_pulse", int'(err_pulse), m_pulse);
    check("err_cnt",   int'(err_cnt),   m_err);
    check("chk_cnt",   int'(chk_cnt),   m_chk);
  end

  always @(negedge clk) begin
    if (err_pulse) n_pulse++;
    if (done)      n_done++;
  end

  // kind 0: ideal latch; 1: q stuck 0, qb=~q; 2: qb tied to q;
  // 3: en held low, q random, qb wrong on every 5th sample.
  task automatic do_run(input int kind, input int abort_at);
    logic lq;
    lq = 1'b0;
    @(negedge clk);
    n_pulse = 0;
    n_done  = 0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < WIN; k++) begin
      @(negedge clk);
      en = ((k / 4) % 2 == 0);
      d  = ((k / 8) % 2 == 1);
      if (kind == 3) en = 1'b0;
      if (en) lq = d;
      case (kind)
        1:       begin q = 1'b0; qb = 1'b1; end
        2:       begin q = lq;   qb = lq;   end
        3:       begin q = 1'($urandom_range(0, 1)); qb = (k % 5 == 0) ? q : ~q; end
        default: begin q = lq;   qb = ~lq;  end
      endcase
      start = (k == 20);
      abort = (k == abort_at);
      if (k == abort_at) break;
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #12;
    check("reset_busy",    int'(busy),    0);
    check("reset_err_cnt", int'(err_cnt), 0);
    check("reset_chk_cnt", int'(chk_cnt), 0);
    check("reset_pass",    int'(pass),    0);
    #11 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // q stuck at 0: expected 1 on samples 8..15 and 24..31 -> 16 errors, sat 15
    do_run(1, -1);
    check("stuck_err_cnt", int'(err_cnt), 15);
    check("stuck_pulses",  n_pulse,       16);
    check("stuck_chk_cnt", int'(chk_cnt), 40);
    check("stuck_done",    n_done,        1);
    check("stuck_pass",    int'(pass),    0);

    // qb tied to q: every sample wrong
    do_run(2, -1);
    check("qbq_err_cnt", int'(err_cnt), 15);
    check("qbq_pulses",  n_pulse,       40);
    check("qbq_pass",    int'(pass),    0);

    // en always low: only the 8 bad-qb samples count
    do_run(3, -1);
    check("en0_err_cnt", int'(err_cnt), 8);
    check("en0_pulses",  n_pulse,       8);
    check("en0_pass",    int'(pass),    0);

    // good latch (start re-issued mid-run is ignored)
    do_run(0, -1);
    check("good_err_cnt", int'(err_cnt), 0);
    check("good_chk_cnt", int'(chk_cnt), 40);
    check("good_done",    n_done,        1);
    check("good_pass",    int'(pass),    1);

    // abort on the 10th CHECK cycle with qb tied to q
    do_run(2, 9);
    check("abort_chk_cnt", int'(chk_cnt), 9);
    check("abort_err_cnt", int'(err_cnt), 9);
    check("abort_done",    n_done,        0);
    check("abort_pass",    int'(pass),    1);

    // start together with abort in IDLE
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    check("start_abort_busy2", int'(busy), 0);

    // asynchronous reset in the middle of CHECK
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      en = 1'b1;
      d  = k[0];
      q  = k[0];
      qb = ~k[0];
    end
    check("pre_reset_busy", int'(busy), 1);
    @(posedge clk);
    n_done = 0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",      int'(busy),      0);
    check("arst_done",      int'(done),      0);
    check("arst_pass",      int'(pass),      0);
    check("arst_err_pulse", int'(err_pulse), 0);
    check("arst_err_cnt",   int'(err_cnt),   0);
    check("arst_chk_cnt",   int'(chk_cnt),   0);
    #13 rst_n = 1'b1;
    repeat (45) @(negedge clk);
    check("arst_no_done", n_done,     0);
    check("arst_idle",    int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
